// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage and its synchronous ROM.
// The fetch stage drives address/enable; the ROM returns data one edge later.
interface fetch_unit_if #(
  parameter int IW  = 8,
  parameter int PCW = 10
);
  logic [PCW-1:0] imem_addr;
  logic           imem_en;
  logic [IW-1:0]  imem_rdata;

  modport master (
    output imem_addr,
    output imem_en,
    input  imem_rdata
  );

  modport slave (
    input  imem_addr,
    input  imem_en,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, drives the instruction ROM and presents one
// instruction per cycle to the decoder, with stall/redirect/halt control.
module fetch_unit #(
  parameter int IW       = 8,
  parameter int PCW      = 10,
  parameter int START_PC = 0
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  fetch_unit_if.master   imem,
  output logic [IW-1:0]  instruction,
  output logic [PCW-1:0] inst_pc,
  output logic           inst_valid,
  input  logic           stall,
  input  logic           branch_taken,
  input  logic [PCW-1:0] branch_target,
  input  logic           halt,
  output logic           done
);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN,
    HALTED
  } state_t;

  state_t         state_q, state_d;
  logic [PCW-1:0] fetch_pc_q, fetch_pc_d;
  logic [PCW-1:0] rd_pc_q, rd_pc_d;
  logic           rd_valid_q, rd_valid_d;
  logic           done_q, done_d;

  localparam logic [PCW-1:0] START = PCW'(START_PC);
  localparam logic [PCW-1:0] ONE   = PCW'(1);

  // State register; reset drops any in-flight instruction at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= START;
      rd_pc_q    <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rd_pc_q    <= rd_pc_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
    end
  end

  // Next-state, PC selection and ROM request; stall > halt > branch > seq.
  always_comb begin
    state_d        = state_q;
    fetch_pc_d     = fetch_pc_q;
    rd_pc_d        = rd_pc_q;
    rd_valid_d     = rd_valid_q;
    done_d         = done_q;
    imem.imem_en   = 1'b0;
    imem.imem_addr = fetch_pc_q;
    inst_valid     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          fetch_pc_d = START;
          state_d    = PRIME;
        end
      end
      PRIME: begin
        imem.imem_en = 1'b1;
        rd_pc_d      = fetch_pc_q;
        rd_valid_d   = 1'b1;
        fetch_pc_d   = fetch_pc_q + ONE;
        state_d      = RUN;
      end
      RUN: begin
        inst_valid = rd_valid_q;
        if (stall) begin
          imem.imem_en = 1'b0;
        end else if (halt && rd_valid_q) begin
          rd_valid_d = 1'b0;
          done_d     = 1'b1;
          state_d    = HALTED;
        end else if (branch_taken && rd_valid_q) begin
          imem.imem_addr = branch_target;
          imem.imem_en   = 1'b1;
          rd_pc_d        = branch_target;
          fetch_pc_d     = branch_target + ONE;
        end else begin
          imem.imem_en = 1'b1;
          rd_pc_d      = fetch_pc_q;
          fetch_pc_d   = fetch_pc_q + ONE;
        end
      end
      HALTED: begin
        if (start) begin
          done_d     = 1'b0;
          fetch_pc_d = START;
          state_d    = PRIME;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign instruction = imem.imem_rdata;
  assign inst_pc     = rd_pc_q;
  assign done        = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed plan plus random stall/branch/halt traffic.
// Expected (pc, instruction) pairs are queued and checked by a monitor.
module tb_fetch_unit;
  localparam int IW  = 8;
  localparam int PCW = 10;
  localparam int SPC = 0;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic           start = 1'b0;
  logic           stall = 1'b0;
  logic           branch_taken = 1'b0;
  logic [PCW-1:0] branch_target = '0;
  logic           halt = 1'b0;
  logic [IW-1:0]  instruction;
  logic [PCW-1:0] inst_pc;
  logic           inst_valid;
  logic           done;

  fetch_unit_if #(.IW(IW), .PCW(PCW)) imem_bus ();

  fetch_unit #(.IW(IW), .PCW(PCW), .START_PC(SPC)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .imem          (imem_bus),
    .instruction   (instruction),
    .inst_pc       (inst_pc),
    .inst_valid    (inst_valid),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .halt          (halt),
    .done          (done)
  );

  always #5 clk = ~clk;

  logic [IW-1:0] rom [1 << PCW];

  always @(posedge clk)
    if (imem_bus.imem_en)
      imem_bus.imem_rdata <= rom[imem_bus.imem_addr];

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [PCW-1:0] pc;
    logic [IW-1:0]  ins;
  } exp_t;

  exp_t exp_q [$];
  logic [PCW-1:0] cur_pc;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every consumed instruction must match the head of the queue.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (inst_valid === 1'b1 && stall === 1'b0) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected: inst_valid at pc %0h with nothing expected", inst_pc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("mon_pc", 32'(inst_pc), 32'(e.pc));
          chk("mon_ins", 32'(instruction), 32'(e.ins));
        end
      end
    end
  end

  task automatic drive(bit s, bit b, bit h, logic [PCW-1:0] t);
    stall = s;
    branch_taken = b;
    halt = h;
    branch_target = t;
  endtask

  // Start from IDLE/HALTED; first valid instruction is 2 edges later.
  task automatic do_start();
    @(negedge clk);
    drive(0, 0, 0, '0);
    start = 1'b1;
    #1;
    chk("idle_en", 32'(imem_bus.imem_en), 0);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("prime_en", 32'(imem_bus.imem_en), 1);
    chk("prime_addr", 32'(imem_bus.imem_addr), SPC);
    chk("prime_valid", 32'(inst_valid), 0);
    chk("prime_done", 32'(done), 0);
    cur_pc = PCW'(SPC);
  endtask

  // One RUN cycle with the model deciding what fetch must do.
  task automatic cyc(bit s, bit b, bit h, logic [PCW-1:0] t);
    exp_t e;
    @(negedge clk);
    drive(s, b, h, t);
    #1;
    chk("run_valid", 32'(inst_valid), 1);
    e.pc = cur_pc;
    e.ins = rom[cur_pc];
    if (s) begin
      chk("stall_en", 32'(imem_bus.imem_en), 0);
      chk("stall_pc", 32'(inst_pc), 32'(cur_pc));
      chk("stall_ins", 32'(instruction), 32'(rom[cur_pc]));
    end else if (h) begin
      chk("halt_en", 32'(imem_bus.imem_en), 0);
      exp_q.push_back(e);
    end else if (b) begin
      chk("br_en", 32'(imem_bus.imem_en), 1);
      chk("br_addr", 32'(imem_bus.imem_addr), 32'(t));
      exp_q.push_back(e);
      cur_pc = t;
    end else begin
      chk("seq_en", 32'(imem_bus.imem_en), 1);
      chk("seq_addr", 32'(imem_bus.imem_addr), 32'(PCW'(cur_pc + 1)));
      exp_q.push_back(e);
      cur_pc = PCW'(cur_pc + 1);
    end
  endtask

  task automatic halt_check();
    @(negedge clk);
    drive(0, 0, 0, '0);
    #1;
    chk("halted_done", 32'(done), 1);
    chk("halted_valid", 32'(inst_valid), 0);
    chk("halted_en", 32'(imem_bus.imem_en), 0);
  endtask

  initial begin
    for (int i = 0; i < (1 << PCW); i++) rom[i] = IW'($urandom);
    rom[0] = 8'h80;
    rom[1] = 8'h81;
    rom[2] = 8'h82;
    rom[3] = 8'h78;

    #12;
    chk("rst_valid", 32'(inst_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_en", 32'(imem_bus.imem_en), 0);
    reset_n = 1'b1;

    do_start();
    cyc(0, 0, 0, '0);
    repeat (3) cyc(1, 0, 0, '0);
    cyc(0, 0, 0, '0);
    cyc(0, 0, 0, '0);
    cyc(0, 0, 1, '0);
    halt_check();
    halt_check();

    do_start();
    repeat (5) cyc(0, 0, 0, '0);
    cyc(0, 1, 0, 10'h020);
    cyc(0, 0, 0, '0);
    cyc(1, 1, 0, 10'h100);
    cyc(0, 1, 0, 10'h3FF);
    cyc(0, 0, 0, '0);
    cyc(0, 0, 0, '0);
    cyc(0, 1, 1, 10'h055);
    halt_check();

    do_start();
    repeat (7) cyc(0, 0, 0, '0);
    @(negedge clk);
    drive(0, 0, 0, '0);
    reset_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(inst_valid), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_en", 32'(imem_bus.imem_en), 0);
    @(negedge clk);
    reset_n = 1'b1;

    do_start();
    for (int n = 0; n < 400; n++) begin
      bit s, b, h;
      logic [PCW-1:0] t;
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 5) == 0);
      h = ($urandom_range(0, 39) == 0);
      t = ($urandom_range(0, 7) == 0) ? 10'h3FF : PCW'($urandom);
      cyc(s, b, h, t);
      if (h && !s) begin
        halt_check();
        do_start();
      end
    end
    cyc(0, 0, 1, '0);
    halt_check();
    @(negedge clk);
    #3;
    chk("queue_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
